// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM with byte-enable writes and a
// fixed response latency. One request in flight; the response carries the
// word as it stood on the accept edge (pre-write for stores).
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // Counter preload for WAIT; unused when LATENCY == 1.
  localparam logic [3:0] WaitLoad = 4'(int'(LATENCY) - 2);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rvalid_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          in_range;
  logic          accept;
  logic          unused_addr_lsb;

  assign idx             = data_addr_i[AW+1:2];
  assign in_range        = (data_addr_i[31:AW+2] == '0);
  assign unused_addr_lsb = ^data_addr_i[1:0];

  // Grant only from IDLE and never while reset is held.
  assign data_gnt_o = data_req_i & (state_q == StIdle) & ~arstn_i;
  assign accept     = data_gnt_o;

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;

  // Next-state logic: capture the pre-write word on accept, then count out the latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rdata_d = in_range ? mem_q[idx] : 32'h0;
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state; reset drops any response in flight.
  always_ff @(posedge clk_i or posedge arstn_i) begin
    if (arstn_i) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= (state_d == StResp);
      rdata_q  <= rdata_d;
    end
  end

  // RAM array: not reset; writes commit on the accept edge, out-of-range stores dropped.
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_i[i]) begin
          mem_q[idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 3, 4) driven one at
// a time; a scoreboard queue is filled on grant and drained by a monitor on rvalid.
module tb_dmem_responder;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [31:0] rdata [3];

  int lat_tab [3] = '{1, 3, 4};

  typedef struct {
    int          inst;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .arstn_i(rst[0]), .data_req_i(req[0]), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt[0]),
    .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut_l3 (
    .clk_i(clk), .arstn_i(rst[1]), .data_req_i(req[1]), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt[1]),
    .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut_l4 (
    .clk_i(clk), .arstn_i(rst[2]), .data_req_i(req[2]), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt[2]),
    .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rvalid[k]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rvalid inst=%0d actual=1 required=0 at %0t", k, $time);
        end else begin
          e = exp_q.pop_front();
          check("rvalid_inst", 32'(k), 32'(e.inst));
          if (e.chk) check("rdata", rdata[k], e.data);
        end
      end
    end
  end

  // Issue one request (called #1 after a rising edge); req stays high on return.
  task automatic issue(input int inst, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] e, input bit c);
    int   n;
    exp_t x;
    we    = w;
    be    = b;
    addr  = a;
    wdata = d;
    req[inst] = 1'b1;
    @(negedge clk);
    check("gnt_accept", 32'(gnt[inst]), 32'd1);
    x.inst = inst;
    x.data = e;
    x.chk  = c;
    exp_q.push_back(x);
    @(posedge clk); #1;
    n = 1;
    while (n <= 20) begin
      @(negedge clk);
      if (rvalid[inst]) break;
      check("gnt_low_wait", 32'(gnt[inst]), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat_tab[inst]));
    check("gnt_low_resp", 32'(gnt[inst]), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 3'b111;
    req   = 3'b111;
    we    = 1'b0;
    be    = 4'h0;
    addr  = 32'h0;
    wdata = 32'h0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_gnt", 32'(gnt[k]), 32'd0);
      check("reset_rvalid", 32'(rvalid[k]), 32'd0);
      check("reset_rdata", rdata[k], 32'h0);
    end
    @(posedge clk); #1;
    rst = 3'b000;
    req = 3'b000;
    @(posedge clk); #1;

    // LATENCY 1: full write, read back, byte-lane write, zero-enable write.
    issue(0, 1'b1, 4'hF, 32'h10, 32'h0,        32'h0,        1'b0);
    issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0,        1'b1);
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0,        32'hDEADBEEF, 1'b1);
    issue(0, 1'b1, 4'h4, 32'h12, 32'h55555555, 32'hDEADBEEF, 1'b1);
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0,        32'hDE55BEEF, 1'b1);
    issue(0, 1'b1, 4'h0, 32'h10, 32'h0,        32'hDE55BEEF, 1'b1);
    issue(0, 1'b0, 4'hF, 32'h10, 32'hFFFFFFFF, 32'hDE55BEEF, 1'b1);
    // Out of range: answered, write dropped, no aliasing onto word 0.
    issue(0, 1'b1, 4'hF, 32'h0,    32'h0,        32'h0, 1'b0);
    issue(0, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue(0, 1'b0, 4'hF, 32'h1000, 32'h0,        32'h0, 1'b1);
    issue(0, 1'b0, 4'hF, 32'h0,    32'h0,        32'h0, 1'b1);
    // Back-to-back write then read.
    issue(0, 1'b1, 4'hF, 32'h20, 32'h0,        32'h0,        1'b0);
    issue(0, 1'b1, 4'hF, 32'h20, 32'h12345678, 32'h0,        1'b1);
    issue(0, 1'b0, 4'hF, 32'h20, 32'h0,        32'h12345678, 1'b1);
    req[0] = 1'b0;
    @(posedge clk); #1;

    // LATENCY 3: req held through RESP, re-granted right after.
    issue(1, 1'b1, 4'hF, 32'h8, 32'hA5A5A5A5, 32'h0,        1'b0);
    issue(1, 1'b0, 4'hF, 32'h8, 32'h0,        32'hA5A5A5A5, 1'b1);
    issue(1, 1'b0, 4'hF, 32'h8, 32'h0,        32'hA5A5A5A5, 1'b1);
    req[1] = 1'b0;
    @(posedge clk); #1;

    // LATENCY 4: write accepted, reset in A+2 drops the response, write stays.
    issue(2, 1'b1, 4'hF, 32'h40, 32'h0, 32'h0, 1'b0);
    we    = 1'b1;
    be    = 4'hF;
    addr  = 32'h40;
    wdata = 32'hCAFEF00D;
    req[2] = 1'b1;
    @(negedge clk);
    check("gnt_pre_reset", 32'(gnt[2]), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    we     = 1'b0;
    @(negedge clk);
    check("rst_rvalid", 32'(rvalid[2]), 32'd0);
    check("rst_gnt", 32'(gnt[2]), 32'd0);
    check("rst_rdata", rdata[2], 32'h0);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    issue(2, 1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFEF00D, 1'b1);
    req[2] = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory request protocol: single-port word-addressed data RAM with byte-enable writes and a fixed, parameterised response latency. Sits between the load/store unit's memory port and the RAM array. Accepts one request at a time with a grant, then returns exactly one `rvalid` pulse with the word as it stood at acceptance, for reads and writes alike.

## Interface

- `DEPTH_WORDS`, default 1024: RAM size in 32-bit words; power of two, 16..65536.
- `LATENCY`, default 1: cycles from the accept cycle to the `rvalid` cycle; range 1..15.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `arstn_i` in 1: one clock; reset is asynchronous and active-high. Asserted = 1 clears all control state immediately.
- `data_req_i` in 1: request present; held by the initiator until `rvalid`.
- `data_we_i` in 1: 1 = write, 0 = read.
- `data_be_i` in 4: byte enables for writes; bit i selects bits 8i+7:8i.
- `data_addr_i` in 32: byte address; bits 1:0 ignored.
- `data_wdata_i` in 32: write data, already lane-aligned by the initiator.
- `data_gnt_o` out 1: request accepted this cycle; combinational.
- `data_rvalid_o` out 1: response valid; one-cycle pulse; registered.
- `data_rdata_o` out 32: word at the accepted address at the moment of acceptance; registered.

## Operation

- FSM states: IDLE, WAIT, RESP.
- `data_gnt_o` = `data_req_i` & (state == IDLE) & !`arstn_i`. It is never high in WAIT or RESP.
- Accept edge (IDLE and `data_gnt_o`):
  - Word index = `data_addr_i[AW+1:2]`, where AW = log2(`DEPTH_WORDS`).
  - Capture the word at that index into the `data_rdata_o` register.
  - If `data_we_i`, merge `data_wdata_i` into the word for each set `data_be_i` bit in the same edge. `data_rdata_o` gets the pre-write word.
  - With `data_be_i` = 0, a write changes nothing but still completes normally.
  - Next state: RESP if `LATENCY` == 1. Otherwise WAIT, with the down-counter loaded with `LATENCY`-2.
- WAIT: decrement the counter each cycle; go to RESP on the cycle after the counter reaches 0.
- RESP: `data_rvalid_o` = 1 for this one cycle; next state is IDLE unconditionally.
- Out-of-range addresses (`data_addr_i[31:AW+2]` ≠ 0):
  - Still granted and answered with normal timing.
  - Writes are discarded; `data_rdata_o` = 0.
- `data_rdata_o` holds its last captured value outside RESP. Its value is only meaningful while `data_rvalid_o` = 1.
- Only one request is outstanding at a time. A request held high through RESP is re-granted in the following IDLE cycle.

## Timing

- Reset values: state IDLE, counter 0, `data_rvalid_o` 0, `data_rdata_o` 0, `data_gnt_o` 0.
- RAM contents are not reset.
- With accept in cycle A, `data_rvalid_o` is high exactly in cycle A+`LATENCY`.
- Minimum request-to-request spacing is `LATENCY`+1 cycles, for example A, A+2, A+4 with `LATENCY` = 1.
- `data_gnt_o` can rise in the same cycle `data_req_i` rises when the FSM is in IDLE.
- Reset asserted in WAIT or RESP:
  - Response is dropped; `data_rvalid_o` falls immediately.
  - A write already committed on the accept edge remains committed.
- After reset releases, the first cycle is IDLE and a pending request is granted.
- Inputs other than `data_req_i` are sampled only on the accept edge. Changes during WAIT or RESP have no effect.

## Test plan

- `LATENCY`=1, write 0xDEADBEEF with be=1111 to 0x10: gnt high in the request cycle, rvalid the next cycle with rdata = old word. Then read 0x10: gnt, then rvalid with rdata 0xDEADBEEF.
- Byte write: wdata 0x55555555, be=0100, addr 0x12 → rvalid. Read 0x10 → 0xDE55BEEF, confirming addr[1:0] is ignored and only lane 2 changed.
- `LATENCY`=3 read, req held throughout: gnt high only in cycle A, rvalid high only in A+3, gnt low in A+1..A+3, re-grant in A+4.
- `DEPTH_WORDS`=1024, write 0xFFFFFFFF to 0x1000: still granted and answered. Read 0x1000 → rdata 0. Read 0x0 → unchanged.
- `LATENCY`=4, assert `arstn_i` in cycle A+2 for one cycle: rvalid never pulses for that request, `data_rdata_o` = 0. Req still high after release → granted on the first post-reset cycle with full latency.
- Back-to-back with `LATENCY`=1: write 0x12345678 to 0x20, then read 0x20 with no idle gap beyond RESP. The read grant comes in the cycle after rvalid and the read returns 0x12345678.
